// File: rtl/branch_cmp_pipe.sv
// branch_cmp_pipe: pipelined branch condition and target unit with 1 or 2 register stages, valid/ready handshakes and flush.
// Define BRCMP_STATS_EN to add the saturating handshake counters total_cnt and taken_cnt.
module branch_cmp_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       cmp_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [15:0]      offset,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [WIDTH-1:0] target
`ifdef BRCMP_STATS_EN
  ,
  output logic [31:0]      total_cnt,
  output logic [31:0]      taken_cnt
`endif
);

  typedef enum logic [2:0] {
    OP_EQ  = 3'd0,
    OP_NE  = 3'd1,
    OP_LEZ = 3'd2,
    OP_GTZ = 3'd3,
    OP_LTZ = 3'd4,
    OP_GEZ = 3'd5,
    OP_LT  = 3'd6,
    OP_LTU = 3'd7
  } cmp_op_e;

  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("branch_cmp_pipe: STAGES must be 1 or 2");
  end
  if (WIDTH < 8) begin : g_bad_width
    $error("branch_cmp_pipe: WIDTH must be at least 8");
  end

  cmp_op_e          op;
  logic             a_neg;
  logic             a_zero;
  logic             cond;
  logic [WIDTH-1:0] off_sh;
  logic [WIDTH-1:0] target_d;

  assign op     = cmp_op_e'(cmp_op);
  assign a_neg  = a[WIDTH-1];
  assign a_zero = (a == '0);
  // The word offset becomes a signed byte offset, then is sign-extended or truncated to WIDTH.
  assign off_sh   = WIDTH'($signed({offset, 2'b00}));
  assign target_d = pc + WIDTH'(4) + off_sh;

  always_comb begin
    // NOTE: assign a default before the case so no path leaves cond unassigned (which would infer a latch).
    cond = 1'b0;
    case (op)
      OP_EQ:   cond = (a == b);
      OP_NE:   cond = (a != b);
      OP_LEZ:  cond = a_neg || a_zero;
      OP_GTZ:  cond = !a_neg && !a_zero;
      OP_LTZ:  cond = a_neg;
      OP_GEZ:  cond = !a_neg;
      OP_LT:   cond = ($signed(a) < $signed(b));
      OP_LTU:  cond = (a < b);
      default: cond = 1'b0;
    endcase
  end

  // Index 0 is stage 1 (fed from the inputs); index STAGES-1 drives the outputs.
  logic [STAGES-1:0] s_valid;
  logic [STAGES-1:0] s_taken;
  logic [WIDTH-1:0]  s_target   [STAGES];
  logic [STAGES-1:0] s_load;
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_taken;
  logic [WIDTH-1:0]  src_target [STAGES];

  // A stage may load when it is empty or its occupant moves on this cycle.
  always_comb begin
    s_load[STAGES-1] = !s_valid[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      s_load[k] = !s_valid[k] || s_load[k+1];
    end
  end

  always_comb begin
    src_valid[0]  = in_valid;
    src_taken[0]  = cond;
    src_target[0] = target_d;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k]  = s_valid[k-1];
      src_taken[k]  = s_taken[k-1];
      src_target[k] = s_target[k-1];
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: data fields are reset too, so an empty stage never shows X on taken/target.
      s_valid <= '0;
      s_taken <= '0;
      for (int k = 0; k < STAGES; k++) begin
        s_target[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush) begin
          s_valid[k] <= 1'b0;
        end else if (s_load[k]) begin
          s_valid[k] <= src_valid[k];
        end
        // Data changes only when a real entry arrives, keeping stalled outputs stable.
        if (s_load[k] && src_valid[k]) begin
          s_taken[k]  <= src_taken[k];
          s_target[k] <= src_target[k];
        end
      end
    end
  end

  assign in_ready  = s_load[0];
  assign out_valid = s_valid[STAGES-1];
  assign taken     = s_taken[STAGES-1];
  assign target    = s_target[STAGES-1];

`ifdef BRCMP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      total_cnt <= '0;
      taken_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (total_cnt != '1) begin
        total_cnt <= total_cnt + 32'd1;
      end
      if (taken && taken_cnt != '1) begin
        taken_cnt <= taken_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
